vend_ctrl_param: RTL and testbench

Parametrised vending-machine controller: debounces N coin inputs and M product-select inputs, keeps a binary credit balance, and issues a vend request to the dispenser via a valid/ack handshake. On refund it pays change greedily through a coin-payout handshake. It drives a time-multiplexed, active-low, DIGITS-wide 7-segment display of the balance. It sits between the board buttons/switches and the dispenser/payout mechanics, and replaces the fixed 3-coin/2-product controller.

---
 rtl/vend_ctrl_param.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_vend_ctrl_param.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_ctrl_param.sv
// Parametrised vending-machine controller: debounced coin/product inputs,
// binary credit balance, vend valid/ack and greedy change payout handshakes,
// and a multiplexed active-low 7-segment balance display.
module vend_ctrl_param #(
  parameter int unsigned                NUM_COINS = 3,
  parameter logic [NUM_COINS*10-1:0]    COIN_VAL  = {10'd50, 10'd10, 10'd5},
  parameter int unsigned                NUM_GOODS = 4,
  parameter logic [NUM_GOODS*10-1:0]    PRICE     = {10'd40, 10'd30, 10'd25, 10'd15},
  parameter int unsigned                MAX_BAL   = 999,
  parameter logic [19:0]                DEBOUNCE  = 20'd50000,
  parameter logic [12:0]                SCAN_DIV  = 13'd5000,
  parameter int unsigned                DIGITS    = 3,
  localparam int unsigned               CW = (NUM_COINS > 1) ? $clog2(NUM_COINS) : 1,
  localparam int unsigned               GW = (NUM_GOODS > 1) ? $clog2(NUM_GOODS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_COINS-1:0] coin,
  input  logic [NUM_GOODS-1:0] buy,
  input  logic                 refund,
  input  logic                 clear,
  output logic                 vend_valid,
  output logic [GW-1:0]        vend_idx,
  input  logic                 vend_ack,
  output logic                 chg_valid,
  output logic [CW-1:0]        chg_idx,
  input  logic                 chg_ready,
  output logic [3:0]           light,
  output logic [DIGITS-1:0]    en,
  output logic [7:0]           lit
);

  localparam int unsigned NIN       = NUM_COINS + NUM_GOODS + 2;
  localparam int unsigned DW        = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [10:0] MAX_BAL_W = 11'(MAX_BAL);
  localparam logic [9:0]  MIN_COIN  = COIN_VAL[9:0];

  typedef enum logic [1:0] {S_IDLE, S_VEND, S_CHANGE} state_e;

  // ---------------------------------------------------------------------------
  // Reset: asserts asynchronously, releases synchronously to clk
  // ---------------------------------------------------------------------------
  logic rst_meta_q, rst_sync_q;

  // two-stage reset release synchronizer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Input conditioning: sync, stable-count debounce, rising-edge pulse
  // bit layout: {clear, refund, buy[], coin[]}
  // ---------------------------------------------------------------------------
  logic [NIN-1:0] raw, sync1_q, sync2_q, level_q, level_d, prev_q, pulse;
  logic [19:0]    cnt_q [NIN];
  logic [19:0]    cnt_d [NIN];

  assign raw = {clear, refund, buy, coin};

  // accept a new level once it has differed for DEBOUNCE consecutive cycles
  always_comb begin
    level_d = level_q;
    for (int unsigned i = 0; i < NIN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (21'(cnt_q[i]) + 21'd1 >= 21'(DEBOUNCE)) level_d[i] = sync2_q[i];
        else                                         cnt_d[i]   = cnt_q[i] + 20'd1;
      end
    end
  end

  // synchronizer, debounce and edge-detect registers
  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      prev_q  <= '0;
      for (int unsigned i = 0; i < NIN; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      prev_q  <= level_q;
      for (int unsigned i = 0; i < NIN; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign pulse = level_q & ~prev_q;

  logic [NUM_COINS-1:0] coin_p;
  logic [NUM_GOODS-1:0] buy_p;
  logic                 refund_p, clear_p;

  assign coin_p   = pulse[NUM_COINS-1:0];
  assign buy_p    = pulse[NUM_COINS +: NUM_GOODS];
  assign refund_p = pulse[NIN-2];
  assign clear_p  = pulse[NIN-1];

  // ---------------------------------------------------------------------------
  // Arbitration helpers and greedy change selection
  // ---------------------------------------------------------------------------
  logic          buy_hit, coin_hit;
  logic [GW-1:0] buy_sel;
  logic [9:0]    price_amt, coin_amt, chg_val;
  logic [CW-1:0] chg_sel;
  logic          chg_avail;
  logic [9:0]    bal_q, bal_d;

  // lowest-index buy and highest-index coin win; largest coin not above balance
  always_comb begin
    buy_hit   = 1'b0;
    buy_sel   = '0;
    price_amt = PRICE[9:0];
    for (int unsigned j = NUM_GOODS; j > 0; j--) begin
      if (buy_p[j-1]) begin
        buy_hit   = 1'b1;
        buy_sel   = GW'(j-1);
        price_amt = PRICE[(j-1)*10 +: 10];
      end
    end
    coin_hit = 1'b0;
    coin_amt = COIN_VAL[9:0];
    chg_sel  = '0;
    chg_val  = MIN_COIN;
    for (int unsigned k = 0; k < NUM_COINS; k++) begin
      if (coin_p[k]) begin
        coin_hit = 1'b1;
        coin_amt = COIN_VAL[k*10 +: 10];
      end
      if (COIN_VAL[k*10 +: 10] <= bal_q) begin
        chg_sel = CW'(k);
        chg_val = COIN_VAL[k*10 +: 10];
      end
    end
  end

  assign chg_avail = (bal_q >= MIN_COIN);

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  state_e        state_q, state_d;
  logic [3:0]    light_q, light_d;
  logic [GW-1:0] vend_idx_q, vend_idx_d;
  logic [9:0]    bal_after;

  // state, balance, status and vend index registers
  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q    <= S_IDLE;
      bal_q      <= '0;
      light_q    <= '0;
      vend_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      bal_q      <= bal_d;
      light_q    <= light_d;
      vend_idx_q <= vend_idx_d;
    end
  end

  // next-state and datapath update; one event per cycle in IDLE
  always_comb begin
    state_d    = state_q;
    bal_d      = bal_q;
    light_d    = light_q;
    vend_idx_d = vend_idx_q;
    bal_after  = bal_q - chg_val;
    unique case (state_q)
      S_IDLE: begin
        if (clear_p) begin
          bal_d   = '0;
          light_d = 4'b0000;
        end else if (refund_p) begin
          if (bal_q == '0) light_d = 4'b0100;
          else             state_d = S_CHANGE;
        end else if (buy_hit) begin
          if (bal_q < price_amt) begin
            light_d = 4'b0001;
          end else begin
            bal_d      = bal_q - price_amt;
            vend_idx_d = buy_sel;
            state_d    = S_VEND;
          end
        end else if (coin_hit) begin
          if ({1'b0, bal_q} + {1'b0, coin_amt} <= MAX_BAL_W) begin
            bal_d   = bal_q + coin_amt;
            light_d = 4'b0000;
          end else begin
            light_d = 4'b1000;
          end
        end
      end
      S_VEND: begin
        if (vend_ack) begin
          state_d = S_IDLE;
          light_d = 4'b0010;
        end
      end
      S_CHANGE: begin
        // finishing on the edge of the last transfer keeps chg_valid from
        // lingering a cycle with nothing payable
        if (!chg_avail) begin
          bal_d   = '0;
          light_d = 4'b0100;
          state_d = S_IDLE;
        end else if (chg_ready) begin
          if (bal_after < MIN_COIN) begin
            bal_d   = '0;
            light_d = 4'b0100;
            state_d = S_IDLE;
          end else begin
            bal_d = bal_after;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // handshake and status outputs
  always_comb begin
    vend_valid = (state_q == S_VEND);
    vend_idx   = vend_idx_q;
    chg_valid  = (state_q == S_CHANGE) && chg_avail;
    chg_idx    = chg_sel;
    light      = light_q;
  end

  // ---------------------------------------------------------------------------
  // Display scan
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0000100;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  logic [12:0]       scan_cnt_q, scan_cnt_d;
  logic [DW-1:0]     scan_idx_q, scan_idx_d;
  logic [DIGITS-1:0] en_q, en_d;
  logic [7:0]        lit_q, lit_d;
  logic [9:0]        rem;
  logic [3:0]        digit;

  // slot timer, digit select, and segment pattern for the active digit
  always_comb begin
    scan_cnt_d = scan_cnt_q + 13'd1;
    scan_idx_d = scan_idx_q;
    en_d       = en_q;
    if (14'(scan_cnt_q) + 14'd1 >= 14'(SCAN_DIV)) begin
      scan_cnt_d = '0;
      if (32'(scan_idx_q) == DIGITS - 1) scan_idx_d = '0;
      else                               scan_idx_d = scan_idx_q + DW'(1);
      en_d = ~(DIGITS'(1) << scan_idx_d);
    end
    rem   = bal_q;
    digit = '0;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (DW'(d) == scan_idx_d) digit = 4'(rem % 10'd10);
      rem = rem / 10'd10;
    end
    lit_d = {(scan_idx_d != '0), seg7(digit)};
  end

  // display registers
  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
      en_q       <= ~DIGITS'(1);
      lit_q      <= 8'b0000_0001;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
      en_q       <= en_d;
      lit_q      <= lit_d;
    end
  end

  assign en  = en_q;
  assign lit = lit_q;

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Self-checking bench for vend_ctrl_param: directed vector table, hand-written
// corner sequences, and random operations against an event-level model.
module tb_vend_ctrl_param;

  localparam int SD   = 4;
  localparam int HOLD = 8;
  localparam int OP_COIN = 0, OP_BUY = 1, OP_REFUND = 2, OP_CLEAR = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] coin = '0;
  logic [3:0] buy = '0;
  logic       refund = 1'b0, clear = 1'b0, vend_ack = 1'b0, chg_ready = 1'b0;
  logic       vend_valid, chg_valid;
  logic [1:0] vend_idx, chg_idx;
  logic [3:0] light;
  logic [2:0] en;
  logic [7:0] lit;

  vend_ctrl_param #(
    .DEBOUNCE (20'd2),
    .SCAN_DIV (13'd4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .coin       (coin),
    .buy        (buy),
    .refund     (refund),
    .clear      (clear),
    .vend_valid (vend_valid),
    .vend_idx   (vend_idx),
    .vend_ack   (vend_ack),
    .chg_valid  (chg_valid),
    .chg_idx    (chg_idx),
    .chg_ready  (chg_ready),
    .light      (light),
    .en         (en),
    .lit        (lit)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int coin_val [3] = '{5, 10, 50};
  int price    [4] = '{15, 25, 30, 40};
  logic [6:0] segs [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                            7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
  int saw_vend, saw_chg;

  typedef struct {
    int op;
    int arg;
    int bal;
    int light;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic void add(input int op, input int arg, input int bal, input int lt);
    vec_t v;
    v.op = op; v.arg = arg; v.bal = bal; v.light = lt;
    tbl.push_back(v);
  endfunction

  function automatic void greedy(input int bal, output int n, output int code);
    n = 0; code = 0;
    while (bal >= coin_val[0]) begin
      int k = 0;
      for (int i = 0; i < 3; i++) if (coin_val[i] <= bal) k = i;
      bal -= coin_val[k];
      n++;
      code = code * 4 + k + 1;
    end
  endfunction

  function automatic int decode(input logic [6:0] s);
    decode = -1;
    for (int i = 0; i < 10; i++) if (segs[i] === s) decode = i;
  endfunction

  // read all three digits off the scanned display and compare the number shown
  task automatic chk_disp(input string name, input int exp_bal);
    int val = 0;
    int bad = 0;
    int d, dg;
    bit [2:0] seen = '0;
    for (int cyc = 0; cyc < 3 * SD + 2; cyc++) begin
      @(negedge clk);
      case (en)
        3'b110:  d = 0;
        3'b101:  d = 1;
        3'b011:  d = 2;
        default: d = -1;
      endcase
      if (d < 0) bad = 1;
      else begin
        dg = decode(lit[6:0]);
        if (dg < 0) bad = 1;
        if (lit[7] !== (d != 0)) bad = 1;
        if (!seen[d] && dg >= 0) begin
          seen[d] = 1'b1;
          val += dg * ((d == 0) ? 1 : (d == 1) ? 10 : 100);
        end
      end
    end
    if (seen != 3'b111) bad = 1;
    chk(name, bad ? -1 : val, exp_bal);
  endtask

  task automatic hold_inputs(input logic [2:0] c, input logic [3:0] b, input logic r, input logic cl);
    saw_vend = 0; saw_chg = 0;
    @(negedge clk);
    coin = c; buy = b; refund = r; clear = cl;
    for (int i = 0; i < 2 * HOLD; i++) begin
      if (i == HOLD) begin coin = '0; buy = '0; refund = 1'b0; clear = 1'b0; end
      @(negedge clk);
      if (vend_valid) saw_vend = 1;
      if (chg_valid)  saw_chg  = 1;
    end
  endtask

  task automatic finish_vend(input int exp_idx, input int delay);
    int held = 1;
    chk("vend_idx", vend_idx, exp_idx);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      if (vend_valid !== 1'b1 || vend_idx !== 2'(exp_idx)) held = 0;
    end
    chk("vend_held_until_ack", held, 1);
    vend_ack = 1'b1;
    @(negedge clk);
    vend_ack = 1'b0;
    chk("vend_drop_after_ack", vend_valid, 0);
  endtask

  // mode 0: ready toggles 1/0, mode 1: random ready, otherwise ready held high
  task automatic payout(input int mode, output int ntx, output int code);
    int t = 1;
    ntx = 0; code = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (!chg_valid) break;
      case (mode)
        0:       begin chg_ready = t[0]; t ^= 1; end
        1:       chg_ready = 1'($urandom_range(0, 1));
        default: chg_ready = 1'b1;
      endcase
      if (chg_ready) begin
        ntx++;
        code = code * 4 + int'(chg_idx) + 1;
      end
      @(negedge clk);
    end
    chg_ready = 1'b0;
    chk("chg_done", chg_valid, 0);
  endtask

  task automatic do_op(input int op, input int arg, input int ack_delay, input int rmode,
                       output int vended, output int ntx, output int code);
    case (op)
      OP_COIN:   hold_inputs(3'(1 << arg), '0, 1'b0, 1'b0);
      OP_BUY:    hold_inputs('0, 4'(1 << arg), 1'b0, 1'b0);
      OP_REFUND: hold_inputs('0, '0, 1'b1, 1'b0);
      default:   hold_inputs('0, '0, 1'b0, 1'b1);
    endcase
    vended = saw_vend;
    if (op == OP_BUY && vend_valid) finish_vend(arg, ack_delay);
    ntx = 0; code = 0;
    if (op == OP_REFUND) payout(rmode, ntx, code);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int vended, ntx, code, en_x, ec_x, prev_bal;
    int mbal, mlight, evend, op, arg, r;

    // ---------------- reset ----------------
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_vend_valid", vend_valid, 0);
    chk("rst_vend_idx", vend_idx, 0);
    chk("rst_chg_valid", chg_valid, 0);
    chk("rst_chg_idx", chg_idx, 0);
    chk("rst_light", light, 0);
    chk("rst_en", en, 3'b110);
    chk("rst_lit", lit, 8'b0000_0001);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk_disp("rst_display", 0);

    // ---------------- directed table ----------------
    add(OP_CLEAR, 0, 0, 0);
    add(OP_COIN, 1, 10, 0);
    add(OP_COIN, 0, 15, 0);
    add(OP_BUY, 0, 0, 2);
    add(OP_COIN, 1, 10, 0);
    add(OP_COIN, 1, 20, 0);
    add(OP_BUY, 1, 20, 1);
    add(OP_CLEAR, 0, 0, 0);
    for (int i = 1; i <= 19; i++) add(OP_COIN, 2, 50 * i, 0);
    add(OP_COIN, 1, 960, 0);
    add(OP_COIN, 1, 970, 0);
    add(OP_COIN, 1, 980, 0);
    add(OP_COIN, 2, 980, 8);
    add(OP_COIN, 1, 990, 0);
    add(OP_COIN, 0, 995, 0);
    add(OP_COIN, 0, 995, 8);
    add(OP_BUY, 3, 955, 2);
    add(OP_CLEAR, 0, 0, 0);
    add(OP_REFUND, 0, 0, 4);
    add(OP_COIN, 2, 50, 0);
    add(OP_COIN, 1, 60, 0);
    add(OP_COIN, 0, 65, 0);
    add(OP_REFUND, 0, 0, 4);

    prev_bal = 0;
    foreach (tbl[i]) begin
      do_op(tbl[i].op, tbl[i].arg, 3, 0, vended, ntx, code);
      chk($sformatf("tbl%0d_light", i), light, tbl[i].light);
      chk_disp($sformatf("tbl%0d_display", i), tbl[i].bal);
      if (tbl[i].op == OP_BUY) chk($sformatf("tbl%0d_vended", i), vended, tbl[i].light == 2);
      if (tbl[i].op == OP_REFUND) begin
        greedy(prev_bal, en_x, ec_x);
        chk($sformatf("tbl%0d_chg_count", i), ntx, en_x);
        chk($sformatf("tbl%0d_chg_seq", i), code, ec_x);
      end
      prev_bal = tbl[i].bal;
    end
    // 65 pays out as indices 2,1,0
    chk("chg_seq_65", code, 57);

    // ---------------- same-cycle coin2 + buy0 with bal 20 ----------------
    do_op(OP_COIN, 1, 0, 0, vended, ntx, code);
    do_op(OP_COIN, 1, 0, 0, vended, ntx, code);
    hold_inputs(3'b100, 4'b0001, 1'b0, 1'b0);
    chk("arb_buy_vends", saw_vend, 1);
    if (vend_valid) finish_vend(0, 2);
    chk("arb_light", light, 2);
    chk_disp("arb_display", 5);

    // ---------------- clear together with refund ----------------
    hold_inputs('0, '0, 1'b1, 1'b1);
    chk("clr_ref_no_chg", saw_chg, 0);
    chk("clr_ref_light", light, 0);
    chk_disp("clr_ref_display", 0);

    // ---------------- reset mid-CHANGE ----------------
    do_op(OP_COIN, 2, 0, 0, vended, ntx, code);
    do_op(OP_COIN, 1, 0, 0, vended, ntx, code);
    do_op(OP_COIN, 0, 0, 0, vended, ntx, code);
    hold_inputs('0, '0, 1'b1, 1'b0);
    chk("mid_chg_valid", chg_valid, 1);
    chk("mid_chg_idx0", chg_idx, 2);
    chg_ready = 1'b1;
    @(negedge clk);
    chg_ready = 1'b0;
    chk("mid_chg_idx1", chg_idx, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_chg_valid", chg_valid, 0);
    chk("arst_vend_valid", vend_valid, 0);
    chk("arst_light", light, 0);
    chk("arst_en", en, 3'b110);
    chk("arst_lit", lit, 8'b0000_0001);
    chk("arst_chg_idx", chg_idx, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_disp("arst_display", 0);

    // ---------------- random operations vs model ----------------
    mbal = 0;
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      begin op = OP_COIN;   arg = $urandom_range(0, 2); end
      else if (r < 85) begin op = OP_BUY;    arg = $urandom_range(0, 3); end
      else if (r < 93) begin op = OP_REFUND; arg = 0; end
      else             begin op = OP_CLEAR;  arg = 0; end
      evend = 0; en_x = 0; ec_x = 0;
      case (op)
        OP_COIN: begin
          if (mbal + coin_val[arg] <= 999) begin mbal += coin_val[arg]; mlight = 0; end
          else mlight = 8;
        end
        OP_BUY: begin
          if (mbal < price[arg]) mlight = 1;
          else begin mbal -= price[arg]; mlight = 2; evend = 1; end
        end
        OP_REFUND: begin
          greedy(mbal, en_x, ec_x);
          mbal = 0; mlight = 4;
        end
        default: begin mbal = 0; mlight = 0; end
      endcase
      do_op(op, arg, $urandom_range(0, 4), 1, vended, ntx, code);
      chk($sformatf("rnd%0d_light", n), light, mlight);
      chk_disp($sformatf("rnd%0d_display", n), mbal);
      if (op == OP_BUY) chk($sformatf("rnd%0d_vended", n), vended, evend);
      if (op == OP_REFUND) begin
        chk($sformatf("rnd%0d_chg_count", n), ntx, en_x);
        chk($sformatf("rnd%0d_chg_seq", n), code, ec_x);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
